// File: rtl/matrix_printer_pkg.sv
// Shared definitions for the matrix printer: FSM states, ASCII constants,
// storage geometry and the BCD helper functions.
package matrix_printer_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int MAX_DIM    = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHECK    = 4'd1,
        ST_RD_REQ   = 4'd2,
        ST_RD_WAIT  = 4'd3,
        ST_CONV     = 4'd4,
        ST_EMIT_DIG = 4'd5,
        ST_EMIT_SEP = 4'd6,
        ST_EMIT_CR  = 4'd7,
        ST_EMIT_LF  = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Position of the most significant non-zero digit; 0 when the value is 0,
    // so a zero value still prints exactly one '0'.
    function automatic logic [3:0] lead_digit(input logic [BCD_W-1:0] bcd);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] bcd,
                                              input logic [3:0]       idx);
        return ASCII_ZERO + {4'd0, bcd[{idx, 2'b00} +: 4]};
    endfunction

endpackage

// File: rtl/matrix_printer_bin2bcd_seq.sv
// Sequential double-dabble converter: one cycle to load, 32 shift cycles,
// then a one-cycle done pulse with the 10-digit BCD result held afterwards.
module bin2bcd_seq
    import matrix_printer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done
);

    logic [DATA_W-1:0] shift_r;
    logic [4:0]        cnt_r;
    logic              active_r;
    logic [BCD_W-1:0]  adj_s;

    assign adj_s = dabble(bcd);

    // Load on start, then shift one binary bit into the corrected BCD per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r  <= '0;
            cnt_r    <= 5'd0;
            active_r <= 1'b0;
            bcd      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shift_r  <= bin;
                bcd      <= '0;
                cnt_r    <= 5'd0;
                active_r <= 1'b1;
            end else if (active_r) begin
                bcd     <= {adj_s[BCD_W-2:0], shift_r[DATA_W-1]};
                shift_r <= {shift_r[DATA_W-2:0], 1'b0};
                cnt_r   <= cnt_r + 5'd1;
                if (cnt_r == 5'd31) begin
                    active_r <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    active_r <= 1'b1;
                end
            end else begin
                active_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matrix_printer.sv
// Reads an m x n matrix from storage and streams it as ASCII decimal rows
// ("a b c\r\n") over a valid/ready byte link.
module matrix_printer
    import matrix_printer_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [31:0]       i_m,
    input  logic [31:0]       i_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready
);

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       m_r;
    logic [31:0]       n_r;
    logic [2:0]        row_r;
    logic [2:0]        col_r;
    logic [3:0]        dig_r;
    logic [7:0]        wait_r;

    logic              conv_start_s;
    logic              bcd_done_s;
    logic [BCD_W-1:0]  bcd_s;
    logic [3:0]        lead_s;
    logic              last_col_s;
    logic              last_row_s;
    logic              bad_dim_s;

    // The converter samples i_rd_data directly on the last wait cycle.
    assign conv_start_s = (state_r == ST_RD_WAIT) && (wait_r == 8'(READ_LAT - 1));
    assign lead_s       = lead_digit(bcd_s);
    assign last_col_s   = ({29'd0, col_r} == (n_r - 32'd1));
    assign last_row_s   = ({29'd0, row_r} == (m_r - 32'd1));
    assign bad_dim_s    = (m_r == 32'd0) || (n_r == 32'd0) ||
                          (m_r > 32'(MAX_DIM)) || (n_r > 32'(MAX_DIM));

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .bin   (i_rd_data),
        .bcd   (bcd_s),
        .done  (bcd_done_s)
    );

    // Main sequencer: element walk, read timing and the registered byte emitter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            base_r     <= '0;
            m_r        <= 32'd0;
            n_r        <= 32'd0;
            row_r      <= 3'd0;
            col_r      <= 3'd0;
            dig_r      <= 4'd0;
            wait_r     <= 8'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_rd_addr  <= '0;
            o_tx_data  <= 8'd0;
            o_tx_valid <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        base_r  <= i_base_addr;
                        m_r     <= i_m;
                        n_r     <= i_n;
                        o_busy  <= 1'b1;
                        state_r <= ST_CHECK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (bad_dim_s) begin
                        o_err   <= 1'b1;
                        o_busy  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        o_rd_addr <= base_r;
                        row_r     <= 3'd0;
                        col_r     <= 3'd0;
                        state_r   <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    wait_r  <= 8'd0;
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (conv_start_s) begin
                        state_r <= ST_CONV;
                    end else begin
                        wait_r <= wait_r + 8'd1;
                    end
                end
                ST_CONV: begin
                    if (bcd_done_s) begin
                        dig_r      <= lead_s;
                        o_tx_data  <= digit_char(bcd_s, lead_s);
                        o_tx_valid <= 1'b1;
                        state_r    <= ST_EMIT_DIG;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                ST_EMIT_DIG: begin
                    if (!i_tx_ready) begin
                        state_r <= ST_EMIT_DIG;
                    end else if (dig_r != 4'd0) begin
                        dig_r     <= dig_r - 4'd1;
                        o_tx_data <= digit_char(bcd_s, dig_r - 4'd1);
                    end else if (last_col_s) begin
                        o_tx_data <= ASCII_CR;
                        state_r   <= ST_EMIT_CR;
                    end else begin
                        o_tx_data <= ASCII_SPACE;
                        state_r   <= ST_EMIT_SEP;
                    end
                end
                ST_EMIT_SEP: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        col_r      <= col_r + 3'd1;
                        o_rd_addr  <= o_rd_addr + 8'd1;
                        state_r    <= ST_RD_REQ;
                    end else begin
                        state_r <= ST_EMIT_SEP;
                    end
                end
                ST_EMIT_CR: begin
                    if (i_tx_ready) begin
                        o_tx_data <= ASCII_LF;
                        state_r   <= ST_EMIT_LF;
                    end else begin
                        state_r <= ST_EMIT_CR;
                    end
                end
                ST_EMIT_LF: begin
                    if (!i_tx_ready) begin
                        state_r <= ST_EMIT_LF;
                    end else if (last_row_s) begin
                        o_tx_valid <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        o_tx_valid <= 1'b0;
                        row_r      <= row_r + 3'd1;
                        col_r      <= 3'd0;
                        o_rd_addr  <= o_rd_addr + 8'd1;
                        state_r    <= ST_RD_REQ;
                    end
                end
                ST_DONE: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_busy     <= 1'b0;
                    o_tx_valid <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_printer.sv
// Randomised self-checking bench: a string-level model of the printed matrix
// is compared byte by byte with the DUT stream.
module tb_matrix_printer;

    localparam int READ_LAT  = 2;
    localparam int LAT_MAX   = READ_LAT + 36;
    localparam int RUN_LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_base_addr = 8'd0;
    logic [31:0] i_m = 32'd0;
    logic [31:0] i_n = 32'd0;
    logic        o_busy, o_done, o_err, o_tx_valid;
    logic [7:0]  o_rd_addr, o_tx_data;
    logic [31:0] i_rd_data;
    logic        i_tx_ready = 1'b1;

    always #5 clk = ~clk;

    matrix_printer #(.READ_LAT(READ_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_m         (i_m),
        .i_n         (i_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready)
    );

    // storage model with READ_LAT cycles of address-to-data latency
    logic [31:0] mem [256];
    logic [31:0] pipe [READ_LAT];
    always @(posedge clk) begin
        pipe[0] <= mem[o_rd_addr];
        for (int k = 1; k < READ_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign i_rd_data = pipe[READ_LAT-1];

    int tests = 0;
    int fails = 0;
    int ready_pct = 100;
    int done_cnt, err_cnt, rx_cnt;
    byte unsigned exp_q[$], got_q[$], ref_q[$];
    logic [7:0] addr_exp[$], addr_got[$];
    logic [7:0] last_addr = 8'd0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'd0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    function automatic bit legal(input int unsigned m, input int unsigned n);
        return (m >= 1) && (m <= 5) && (n >= 1) && (n <= 5);
    endfunction

    function automatic string fmt_matrix(input logic [7:0] base, input int unsigned m,
                                         input int unsigned n);
        string s;
        logic [7:0] a;
        s = "";
        for (int unsigned r = 0; r < m; r++) begin
            for (int unsigned c = 0; c < n; c++) begin
                a = base + 8'(r * n + c);
                s = {s, $sformatf("%0d", mem[a])};
                s = {s, (c == n - 1) ? "\r\n" : " "};
            end
        end
        return s;
    endfunction

    task automatic load_model(input logic [7:0] base, input int unsigned m, input int unsigned n);
        string s;
        exp_q.delete();
        addr_exp.delete();
        if (legal(m, n)) begin
            s = fmt_matrix(base, m, n);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            for (int unsigned i = 0; i < m * n; i++) addr_exp.push_back(base + 8'(i));
        end
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] pow10 [5];
        pow10 = '{32'd10, 32'd1000000000, 32'hFFFFFFFF, 32'd99999, 32'd100};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 9));
            2: return pow10[$urandom_range(0, 4)];
            default: return 32'($urandom_range(0, 99999));
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        i_tx_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // compare process: every accepted byte against the model, hold rule, pulses, addresses
    initial forever begin
        @(negedge clk);
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, hold_d});
            hold_v = o_tx_valid && !i_tx_ready;
            hold_d = o_tx_data;
            if (o_tx_valid && i_tx_ready) begin
                rx_cnt++;
                got_q.push_back(o_tx_data);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_extra: got byte %0h expected no byte", o_tx_data);
                end else begin
                    check("tx_byte", o_tx_data, exp_q.pop_front());
                end
            end
            done_cnt += int'(o_done);
            err_cnt  += int'(o_err);
            if (o_busy && o_rd_addr != last_addr) begin
                addr_got.push_back(o_rd_addr);
                last_addr = o_rd_addr;
            end
        end
    end

    task automatic begin_case(input logic [7:0] base, input int unsigned m, input int unsigned n,
                              input int pct);
        ready_pct = pct;
        load_model(base, m, n);
        got_q.delete();
        addr_got.delete();
        done_cnt = 0;
        err_cnt  = 0;
        rx_cnt   = 0;
        last_addr = o_rd_addr;
        i_base_addr = base;
        i_m = m;
        i_n = n;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_base_addr = 8'($urandom);
        i_m = $urandom;
        i_n = $urandom;
        check("busy_after_start", {o_busy, o_err}, 2'b10);
    endtask

    task automatic run_case(input logic [7:0] base, input int unsigned m, input int unsigned n,
                            input int pct);
        int first_v;
        bit ok;
        bit lg;
        lg = legal(m, n);
        begin_case(base, m, n, pct);
        if (!lg) begin
            @(posedge clk); #1;
            check("err_pulse", {o_err, o_busy}, 2'b10);
            @(posedge clk); #1;
            check("err_end", {o_err, o_busy}, 2'b00);
        end
        first_v = -1;
        ok = 1'b0;
        for (int i = 0; i < RUN_LIMIT; i++) begin
            if (o_tx_valid && first_v < 0) first_v = i;
            if (done_cnt + err_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            i_start = o_busy && (rx_cnt == 0) && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        check("finished_in_time", ok, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("bytes_left", exp_q.size(), 0);
        check("done_pulses", done_cnt, lg ? 1 : 0);
        check("err_pulses", err_cnt, lg ? 0 : 1);
        check("busy_end", o_busy, 1'b0);
        check("addr_count", addr_got.size(), addr_exp.size());
        for (int i = 0; i < addr_got.size() && i < addr_exp.size(); i++)
            check("rd_addr", addr_got[i], addr_exp[i]);
        if (lg && pct == 100) check("first_valid_latency", first_v <= LAT_MAX, 1'b1);
        if (!lg) check("no_bytes", rx_cnt, 0);
    endtask

    initial begin
        logic [7:0] base;
        int unsigned m, n;
        bit hit;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_busy, o_done, o_err, o_rd_addr, o_tx_data, o_tx_valid}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        mem[8'h10] = 32'd1; mem[8'h11] = 32'd23; mem[8'h12] = 32'd456; mem[8'h13] = 32'd0;
        check_str("model_2x2", fmt_matrix(8'h10, 2, 2), "1 23\r\n456 0\r\n");
        run_case(8'h10, 2, 2, 100);
        check("len_2x2", got_q.size(), 13);

        mem[8'h20] = 32'hFFFFFFFF;
        mem[8'h21] = 32'd0;
        check_str("model_max", fmt_matrix(8'h20, 1, 1), "4294967295\r\n");
        check_str("model_zero", fmt_matrix(8'h21, 1, 1), "0\r\n");
        run_case(8'h20, 1, 1, 100);
        run_case(8'h21, 1, 1, 100);

        run_case(8'h30, 0, 3, 100);
        run_case(8'h30, 6, 1, 100);

        mem[8'hFE] = 32'd7; mem[8'hFF] = 32'd8; mem[8'h00] = 32'd9;
        check_str("model_wrap", fmt_matrix(8'hFE, 1, 3), "7 8 9\r\n");
        run_case(8'hFE, 1, 3, 100);

        for (int i = 0; i < 6; i++) mem[8'h40 + 8'(i)] = rand_val();
        run_case(8'h40, 2, 3, 100);
        ref_q = got_q;
        run_case(8'h40, 2, 3, 30);
        check("bp_len", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            check("bp_same_stream", got_q[i], ref_q[i]);

        for (int t = 0; t < 8; t++) begin
            m = $urandom_range(0, 6);
            n = $urandom_range(0, 6);
            if (t < 6) begin
                m = $urandom_range(1, 5);
                n = $urandom_range(1, 5);
            end
            base = 8'($urandom);
            if (base == o_rd_addr) base = base + 8'd1;
            for (int unsigned k = 0; k < m * n; k++) mem[base + 8'(k)] = rand_val();
            run_case(base, m, n, $urandom_range(30, 100));
        end

        // reset while the third byte of the 2x2 case is being offered
        mem[8'h10] = 32'd1; mem[8'h11] = 32'd23; mem[8'h12] = 32'd456; mem[8'h13] = 32'd0;
        begin_case(8'h10, 2, 2, 100);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rx_cnt == 2 && o_tx_valid) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("third_byte_reached", hit, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", {o_busy, o_done, o_err, o_rd_addr, o_tx_data, o_tx_valid}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {o_busy, o_done, o_err, o_rd_addr, o_tx_data, o_tx_valid}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_case(8'h10, 2, 2, 100);
        check("len_after_reset", got_q.size(), 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
